// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - opcode/handshake inputs and datapath strobes of the multi-cycle MIPS control FSM
// master = control unit side, slave = datapath side.
interface mc_control_unit_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS main control FSM (Moore strobes, Mealy IR/PC load in FETCH)
// Optional feature macro: MC_CTRL_ADDI_EN enables addi decode and the ADDI_EX/ADDI_WB states.
module mc_control_unit (
  input  logic               clk,
  input  logic               reset,
  mc_control_unit_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'h08;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_R_WB    = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_e;

  state_e     state_q, state_d;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic       illegal_op_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    pc_source_c     = 2'b00;
    illegal_op_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        // IR and PC+4 are committed only on the cycle the fetch completes
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default: begin
            illegal_op_c = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
        state_d     = S_FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset masks every strobe so an abandoned instruction can never write
  assign bus.pc_write      = ~reset & pc_write_c;
  assign bus.pc_write_cond = ~reset & pc_write_cond_c;
  assign bus.i_or_d        = ~reset & i_or_d_c;
  assign bus.mem_read      = ~reset & mem_read_c;
  assign bus.mem_write     = ~reset & mem_write_c;
  assign bus.ir_write      = ~reset & ir_write_c;
  assign bus.mem_to_reg    = ~reset & mem_to_reg_c;
  assign bus.reg_dst       = ~reset & reg_dst_c;
  assign bus.reg_write     = ~reset & reg_write_c;
  assign bus.alu_src_a     = ~reset & alu_src_a_c;
  assign bus.alu_src_b     = reset ? 2'b00 : alu_src_b_c;
  assign bus.alu_op        = reset ? 2'b00 : alu_op_c;
  assign bus.pc_source     = reset ? 2'b00 : pc_source_c;
  assign bus.illegal_op    = ~reset & illegal_op_c;
  assign bus.state         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized self-checking bench for mc_control_unit (honours MC_CTRL_ADDI_EN)
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic reset;
  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef MC_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  exp_st[$], obs_st[$];
  logic [16:0] exp_ct[$], obs_ct[$];

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], illegal_op}
  logic [16:0] obs_ctrl;
  assign obs_ctrl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, bus.illegal_op};

  function automatic bit supported(input logic [5:0] opc);
    return (opc == 6'h00) || (opc == 6'h23) || (opc == 6'h2B) || (opc == 6'h04) ||
           (opc == 6'h02) || (ADDI_EN && opc == 6'h08);
  endfunction

  // Strobe table taken from the per-state description of the control unit
  function automatic logic [16:0] exp_ctrl(input int st, input bit mr, input logic [5:0] opc);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = 11'b0;
    {srcb, aop, psrc} = 6'b0;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pw = mr; end
      1:  begin srcb = 2'b11; ill = !supported(opc); end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
  endfunction

  // Runs one instruction from FETCH; sf/sm = stall cycles in FETCH / the memory state.
  // Entry and exit: 1 time unit after a rising edge, DUT in FETCH.
  task automatic run_instr(input logic [5:0] opc, input int sf, input int sm);
    int path[$];
    case (opc)
      6'h23:   path = '{0, 1, 2, 3, 4};
      6'h2B:   path = '{0, 1, 2, 5};
      6'h00:   path = '{0, 1, 6, 7};
      6'h04:   path = '{0, 1, 8};
      6'h02:   path = '{0, 1, 9};
      6'h08:   if (ADDI_EN) path = '{0, 1, 10, 11}; else path = '{0, 1};
      default: path = '{0, 1};
    endcase
    exp_st.delete(); exp_ct.delete(); obs_st.delete(); obs_ct.delete();
    foreach (path[k]) begin
      int p = path[k];
      bit waits = (p == 0) || (p == 3) || (p == 5);
      int reps = (p == 0) ? sf + 1 : ((p == 3) || (p == 5)) ? sm + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        bit mr = waits ? (r == reps - 1) : 1'($urandom_range(0, 1));
        bus.mem_ready = mr;
        bus.opcode = ((p == 1) || (p == 2) || (p == 10)) ? opc : 6'($urandom);
        exp_st.push_back(4'(p));
        exp_ct.push_back(exp_ctrl(p, mr, opc));
        @(negedge clk);
        obs_st.push_back(bus.state);
        obs_ct.push_back(obs_ctrl);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.state !== 4'd0) begin
        n_err++; $display("FAIL reset_state cyc %0d: got %0d expected 0", i, bus.state);
      end
      n_cmp++;
      if (obs_ctrl !== 17'd0) begin
        n_err++; $display("FAIL reset_outputs cyc %0d: got %h expected 0", i, obs_ctrl);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd0 || obs_ctrl !== exp_ctrl(0, 1'b1, 6'h02)) begin
      n_err++; $display("FAIL reset_release_fetch: got state %0d ctrl %h expected state 0 ctrl %h",
                        bus.state, obs_ctrl, exp_ctrl(0, 1'b1, 6'h02));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd1) begin
      n_err++; $display("FAIL reset_release_decode: got %0d expected 1", bus.state);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd9 || obs_ctrl !== exp_ctrl(9, 1'b1, 6'h02)) begin
      n_err++; $display("FAIL reset_release_jump: got state %0d ctrl %h expected state 9 ctrl %h",
                        bus.state, obs_ctrl, exp_ctrl(9, 1'b1, 6'h02));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    int rw_cnt = 0;
    run_instr(6'h23, 0, 0);
    foreach (exp_st[i]) begin
      n_cmp++;
      if (obs_st[i] !== exp_st[i]) begin
        n_err++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_st[i]);
      end
      n_cmp++;
      if (obs_ct[i] !== exp_ct[i]) begin
        n_err++; $display("FAIL lw_ctrl[%0d]: got %h expected %h", i, obs_ct[i], exp_ct[i]);
      end
      if (obs_ct[i][8]) rw_cnt++;
    end
    n_cmp++;
    if (rw_cnt !== 1) begin
      n_err++; $display("FAIL lw_reg_write_cycles: got %0d expected 1", rw_cnt);
    end
  endtask

  task automatic test_sw_stall();
    int wr_cnt = 0;
    run_instr(6'h2B, 1, 2);
    foreach (exp_st[i]) begin
      n_cmp++;
      if (obs_st[i] !== exp_st[i]) begin
        n_err++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_st[i]);
      end
      n_cmp++;
      if (obs_ct[i] !== exp_ct[i]) begin
        n_err++; $display("FAIL sw_ctrl[%0d]: got %h expected %h", i, obs_ct[i], exp_ct[i]);
      end
      if (obs_st[i] === 4'd5 && obs_ct[i][12] === 1'b1) wr_cnt++;
    end
    n_cmp++;
    if (wr_cnt !== 3) begin
      n_err++; $display("FAIL sw_mem_write_cycles: got %0d expected 3", wr_cnt);
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops[4] = '{6'h04, 6'h02, 6'h00, 6'h04};
    foreach (ops[k]) begin
      run_instr(ops[k], k, 0);
      foreach (exp_st[i]) begin
        n_cmp++;
        if (obs_st[i] !== exp_st[i] || obs_ct[i] !== exp_ct[i]) begin
          n_err++; $display("FAIL br_j_r op %h [%0d]: got state %0d ctrl %h expected state %0d ctrl %h",
                            ops[k], i, obs_st[i], obs_ct[i], exp_st[i], exp_ct[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int ill_cnt = 0;
    int wr_cnt = 0;
    run_instr(6'h3F, 0, 0);
    run_instr(6'h08, 0, 0);
    foreach (exp_st[i]) begin
      n_cmp++;
      if (obs_st[i] !== exp_st[i] || obs_ct[i] !== exp_ct[i]) begin
        n_err++; $display("FAIL addi_op [%0d]: got state %0d ctrl %h expected state %0d ctrl %h",
                          i, obs_st[i], obs_ct[i], exp_st[i], exp_ct[i]);
      end
    end
    run_instr(6'h3F, 2, 0);
    foreach (exp_st[i]) begin
      n_cmp++;
      if (obs_st[i] !== exp_st[i] || obs_ct[i] !== exp_ct[i]) begin
        n_err++; $display("FAIL illegal [%0d]: got state %0d ctrl %h expected state %0d ctrl %h",
                          i, obs_st[i], obs_ct[i], exp_st[i], exp_ct[i]);
      end
      if (obs_ct[i][0]) ill_cnt++;
      if (obs_ct[i][8] || obs_ct[i][12]) wr_cnt++;
    end
    n_cmp++;
    if (ill_cnt !== 1) begin
      n_err++; $display("FAIL illegal_pulse_cycles: got %0d expected 1", ill_cnt);
    end
    n_cmp++;
    if (wr_cnt !== 0) begin
      n_err++; $display("FAIL illegal_write_strobes: got %0d expected 0", wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.opcode = 6'h23;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd3) begin
      n_err++; $display("FAIL midreset_pre_state: got %0d expected 3", bus.state);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd0 || obs_ctrl !== 17'd0) begin
      n_err++; $display("FAIL midreset_held: got state %0d ctrl %h expected state 0 ctrl 0",
                        bus.state, obs_ctrl);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd0 || obs_ctrl !== exp_ctrl(0, 1'b0, 6'h23)) begin
      n_err++; $display("FAIL midreset_after: got state %0d ctrl %h expected state 0 ctrl %h",
                        bus.state, obs_ctrl, exp_ctrl(0, 1'b0, 6'h23));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pool[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] opc = pool[$urandom_range(0, 7)];
      if (opc == 6'h11) opc = 6'($urandom);
      run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
      foreach (exp_st[i]) begin
        n_cmp++;
        if (obs_st[i] !== exp_st[i] || obs_ct[i] !== exp_ct[i]) begin
          n_err++; $display("FAIL b2b #%0d op %h [%0d]: got state %0d ctrl %h expected state %0d ctrl %h",
                            n, opc, i, obs_st[i], obs_ct[i], exp_st[i], exp_ct[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch_jump();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
